// File: rtl/sram_lp_pkg.sv
// Shared types and constants for the low-power banked SRAM wrapper:
// bank power-state encoding, counter widths and the bank-select width helper.
package sram_lp_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } bank_state_e;

  localparam int IDLE_CNT_W = 8;
  localparam int WAKE_CNT_W = 4;

  function automatic int bank_sel_w(input int num_banks);
    return $clog2(num_banks);
  endfunction

endpackage

// File: rtl/sp_sram_macro.sv
// Generic single-port SRAM macro model with per-bit active-low write mask and
// a light-sleep pin that blocks all access while asserted.
module sp_sram_macro #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 14
) (
  input  logic              clk_i,
  input  logic              cen_i,
  input  logic              wen_i,
  input  logic [DATA_W-1:0] bwen_i,
  input  logic [ROW_W-1:0]  a_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              ls_i,
  output logic [DATA_W-1:0] q_o
);

  // NOTE: the storage array has no reset; clearing a RAM needs a sweep, not a reset branch.
  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!cen_i && !ls_i) begin
      if (!wen_i) begin
        mem_q[a_i] <= (mem_q[a_i] & bwen_i) | (d_i & ~bwen_i);
      end else begin
        q_q <= mem_q[a_i];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sram_bank_pwr_ctrl.sv
// Per-bank power controller: idle timer drives light-sleep entry, a pending
// request starts a fixed-length wake before the bank accepts accesses again.
module sram_bank_pwr_ctrl
  import sram_lp_pkg::*;
#(
  parameter int SLEEP_IDLE = 16,
  parameter int WAKE_CYC   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bank_req_i,
  input  logic bank_acc_i,
  output logic active_o,
  output logic ls_o
);

  bank_state_e           state_q;
  logic [IDLE_CNT_W-1:0] idle_q;
  logic [WAKE_CNT_W-1:0] wake_q;
  logic                  active_q;
  logic                  ls_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_ACTIVE;
      idle_q   <= '0;
      wake_q   <= '0;
      active_q <= 1'b1;
      ls_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (bank_acc_i) begin
            idle_q <= '0;
          end else if (SLEEP_IDLE != 0 && idle_q == IDLE_CNT_W'(SLEEP_IDLE - 1)) begin
            state_q  <= ST_SLEEP;
            idle_q   <= '0;
            active_q <= 1'b0;
            ls_q     <= 1'b1;
          end else if (idle_q != '1) begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_SLEEP: begin
          if (bank_req_i) begin
            state_q <= ST_WAKE;
            wake_q  <= WAKE_CNT_W'(WAKE_CYC - 1);
            ls_q    <= 1'b0;
          end
        end
        ST_WAKE: begin
          // A withdrawn request does not abort the wake; the bank always finishes it.
          if (wake_q == '0) begin
            state_q  <= ST_ACTIVE;
            idle_q   <= '0;
            active_q <= 1'b1;
          end else begin
            wake_q <= wake_q - 1'b1;
          end
        end
        default: begin
          state_q  <= ST_ACTIVE;
          idle_q   <= '0;
          active_q <= 1'b1;
          ls_q     <= 1'b0;
        end
      endcase
    end
  end

  assign active_o = active_q;
  assign ls_o     = ls_q;

endmodule

// File: rtl/sp_banked_mem_lp_wrapper.sv
// Banked single-port SRAM wrapper: address-MSB bank decode, per-bank light-sleep
// with wake stall, and a tracked read-return path with optional output register.
module sp_banked_mem_lp_wrapper
  import sram_lp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int NUM_BANKS  = 4,
  parameter int SLEEP_IDLE = 16,
  parameter int WAKE_CYC   = 2,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic                  WEN,
  input  logic [DATA_W/8-1:0]   BWEN,
  input  logic [ADDR_W-1:0]     A,
  input  logic [DATA_W-1:0]     D,
  output logic                  READY,
  output logic [DATA_W-1:0]     Q,
  output logic                  QVALID,
  output logic [NUM_BANKS-1:0]  LS_STATUS
);

  localparam int BANK_SEL_W = bank_sel_w(NUM_BANKS);
  localparam int ROW_W      = ADDR_W - BANK_SEL_W;
  localparam int BYTES      = DATA_W / 8;

  logic [BANK_SEL_W-1:0] bank_sel;
  logic [ROW_W-1:0]      row;
  logic [DATA_W-1:0]     bit_mask;
  logic [NUM_BANKS-1:0]  bank_req;
  logic [NUM_BANKS-1:0]  bank_acc;
  logic [NUM_BANKS-1:0]  bank_active;
  logic [NUM_BANKS-1:0]  bank_ls;
  logic [DATA_W-1:0]     macro_q [NUM_BANKS];

  logic                  rd_acc;
  logic [NUM_BANKS-1:0]  rd_sel_d;
  logic [NUM_BANKS-1:0]  rd_sel_q;
  logic                  rd_pend_q;
  logic [DATA_W-1:0]     rd_data;

  assign bank_sel = A[ADDR_W-1 -: BANK_SEL_W];
  assign row      = A[ROW_W-1:0];

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      bit_mask[i*8 +: 8] = {8{BWEN[i]}};
    end
  end

  // READY is combinational so a stalled master sees the wake without a bubble.
  assign READY  = CEN | bank_active[bank_sel];
  assign rd_acc = !CEN && bank_active[bank_sel] && WEN;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_req[b] = !CEN && (bank_sel == BANK_SEL_W'(b));
    assign bank_acc[b] = bank_req[b] && bank_active[b];

    sram_bank_pwr_ctrl #(
      .SLEEP_IDLE (SLEEP_IDLE),
      .WAKE_CYC   (WAKE_CYC)
    ) u_pwr (
      .clk_i      (CLK),
      .rst_i      (RST),
      .bank_req_i (bank_req[b]),
      .bank_acc_i (bank_acc[b]),
      .active_o   (bank_active[b]),
      .ls_o       (bank_ls[b])
    );

    sp_sram_macro #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_macro (
      .clk_i  (CLK),
      .cen_i  (!bank_acc[b]),
      .wen_i  (bank_acc[b] ? WEN : 1'b1),
      .bwen_i (bit_mask),
      .a_i    (row),
      .d_i    (D),
      .ls_i   (bank_ls[b]),
      .q_o    (macro_q[b])
    );
  end

  always_comb begin
    rd_sel_d           = '0;
    rd_sel_d[bank_sel] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend_q <= 1'b0;
      rd_sel_q  <= '0;
    end else begin
      rd_pend_q <= rd_acc;
      if (rd_acc) begin
        rd_sel_q <= rd_sel_d;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_sel_q[b]) begin
        rd_data = rd_data | macro_q[b];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] q_q;
    logic              qvalid_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_q      <= '0;
        qvalid_q <= 1'b0;
      end else begin
        qvalid_q <= rd_pend_q;
        if (rd_pend_q) begin
          q_q <= rd_data;
        end
      end
    end

    assign Q      = q_q;
    assign QVALID = qvalid_q;
  end else begin : g_out_comb
    // Holding register keeps Q at the last returned word between reads.
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_q <= '0;
      end else if (rd_pend_q) begin
        q_q <= rd_data;
      end
    end

    assign Q      = rd_pend_q ? rd_data : q_q;
    assign QVALID = rd_pend_q;
  end

  assign LS_STATUS = bank_ls;

endmodule
